alu_insa_pipe: RTL and testbench



---
 rtl/ariane_pkg.sv | 40 ++++
 rtl/alu_insa_pipe_if.sv | 38 +++
 rtl/alu_insa_core.sv | 68 ++++++
 rtl/alu_insa_pipe.sv | 167 ++++++++++++++++
 tb/tb_alu_insa_pipe.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// Shared types for the INSA-extended execute-stage ALU: operator encoding,
// functional-unit payload, ALU pipe FSM states and buffer channel mapping.
package ariane_pkg;

    localparam int unsigned DATA_W = 64;

    typedef enum logic [7:0] {
        ADD, SUB, ADDW, SUBW,
        XORL, ORL, ANDL,
        SRA, SRL, SLL, SRLW, SLLW, SRAW,
        LTS, LTU, GES, GEU, EQ, NE,
        SLTS, SLTU,
        INSAFIRST, INSALAST, RSTBUF, ENCRASH, CLRCRASH
    } fu_op_t;

    typedef struct packed {
        fu_op_t              operation;
        logic [DATA_W-1:0]   operand_a;
        logic [DATA_W-1:0]   operand_b;
        logic [DATA_W-1:0]   imm;
    } fu_data_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUF_WAIT = 2'd1,
        HOLD     = 2'd2
    } alu_state_e;

    localparam int unsigned CH_INSAFIRST = 0;
    localparam int unsigned CH_INSALAST  = 1;

    function automatic logic is_buf_op(fu_op_t op);
        return (op == INSAFIRST) || (op == INSALAST);
    endfunction

    function automatic int unsigned insa_channel(fu_op_t op);
        return (op == INSALAST) ? CH_INSALAST : CH_INSAFIRST;
    endfunction

endpackage

// File: rtl/alu_insa_pipe_if.sv
// Operation handshake, result handshake and shadow-buffer read port of the
// INSA ALU pipe; slave is the ALU's view, master the surrounding stage's view.
interface alu_insa_pipe_if import ariane_pkg::*; #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned IDX_W  = 20,
    parameter int unsigned NUM_CH = 2
) ();
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    fu_data_t           fu_data_i;
    logic               valid_i;
    logic               ready_o;
    logic [XLEN-1:0]    result_o;
    logic               branch_res_o;
    logic               result_valid_o;
    logic               result_ready_i;
    logic               buf_rd_req_o;
    logic [CH_W-1:0]    buf_rd_ch_o;
    logic [IDX_W-1:0]   buf_rd_idx_o;
    logic               buf_rd_valid_i;
    logic [31:0]        buf_rd_data_i;
    logic               buf_err_o;
    logic               rst_buf_o;
    logic               en_crash_o;

    modport slave (
        input  fu_data_i, valid_i, result_ready_i, buf_rd_valid_i, buf_rd_data_i,
        output ready_o, result_o, branch_res_o, result_valid_o, buf_rd_req_o,
               buf_rd_ch_o, buf_rd_idx_o, buf_err_o, rst_buf_o, en_crash_o
    );

    modport master (
        output fu_data_i, valid_i, result_ready_i, buf_rd_valid_i, buf_rd_data_i,
        input  ready_o, result_o, branch_res_o, result_valid_o, buf_rd_req_o,
               buf_rd_ch_o, buf_rd_idx_o, buf_err_o, rst_buf_o, en_crash_o
    );

endinterface

// File: rtl/alu_insa_core.sv
// Combinational RV64I-style datapath: add/sub, logic, shifts, set-less-than
// and branch compares. Non-branch operators report branch_res = 1.
module alu_insa_core import ariane_pkg::*; #(
    parameter int unsigned XLEN = 64
) (
    input  fu_op_t           op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  result,
    output logic             branch_res
);
    localparam int unsigned SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt_s;
    logic [4:0]      shamt_w_s;
    logic [31:0]     w_add_s, w_sub_s, w_sll_s, w_srl_s, w_sra_s;
    logic            lts_s, ltu_s, eq_s;

    // Size cast of a signed value replicates the sign bit up to XLEN.
    function automatic logic [XLEN-1:0] sext32(logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    assign shamt_s   = b[SH_W-1:0];
    assign shamt_w_s = b[4:0];
    assign w_add_s   = a[31:0] + b[31:0];
    assign w_sub_s   = a[31:0] - b[31:0];
    assign w_sll_s   = a[31:0] << shamt_w_s;
    assign w_srl_s   = a[31:0] >> shamt_w_s;
    assign w_sra_s   = $signed(a[31:0]) >>> shamt_w_s;
    assign lts_s     = $signed(a) < $signed(b);
    assign ltu_s     = a < b;
    assign eq_s      = a == b;

    // Operator decode into result and branch outcome.
    always_comb begin
        result     = {XLEN{1'b0}};
        branch_res = 1'b1;
        case (op)
            ADD:     result = a + b;
            SUB:     result = a - b;
            ADDW:    result = sext32(w_add_s);
            SUBW:    result = sext32(w_sub_s);
            XORL:    result = a ^ b;
            ORL:     result = a | b;
            ANDL:    result = a & b;
            SLL:     result = a << shamt_s;
            SRL:     result = a >> shamt_s;
            SRA:     result = $signed(a) >>> shamt_s;
            SLLW:    result = sext32(w_sll_s);
            SRLW:    result = sext32(w_srl_s);
            SRAW:    result = sext32(w_sra_s);
            SLTS:    result = {{(XLEN-1){1'b0}}, lts_s};
            SLTU:    result = {{(XLEN-1){1'b0}}, ltu_s};
            LTS:     branch_res = lts_s;
            LTU:     branch_res = ltu_s;
            GES:     branch_res = ~lts_s;
            GEU:     branch_res = ~ltu_s;
            EQ:      branch_res = eq_s;
            NE:      branch_res = ~eq_s;
            default: begin
                result     = {XLEN{1'b0}};
                branch_res = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_insa_pipe.sv
// Registered, handshaked INSA ALU: one-cycle ALU results, multi-cycle shadow
// buffer reads with timeout, buffer-clear pulse and sticky crash enable.
module alu_insa_pipe import ariane_pkg::*; #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned IDX_W   = 20,
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    alu_insa_pipe_if.slave  bus
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    alu_state_e         state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [XLEN-1:0]    result_r, result_s;
    logic               branch_r, branch_s;
    logic               valid_r, valid_s;
    logic               req_r, req_s;
    logic [CH_W-1:0]    ch_r, ch_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic               err_r, err_s;
    logic               rst_buf_r, rst_buf_s;
    logic               crash_r, crash_s;
    logic               ready_s, accept_s;
    logic [XLEN-1:0]    core_result_s;
    logic               core_branch_s;
    fu_op_t             op_s;
    logic               unused_imm_s;

    assign op_s         = bus.fu_data_i.operation;
    assign unused_imm_s = ^bus.fu_data_i.imm[DATA_W-1:IDX_W];

    alu_insa_core #(.XLEN(XLEN)) u_core (
        .op         (op_s),
        .a          (bus.fu_data_i.operand_a[XLEN-1:0]),
        .b          (bus.fu_data_i.operand_b[XLEN-1:0]),
        .result     (core_result_s),
        .branch_res (core_branch_s)
    );

    // Accept in IDLE, or in HOLD when the consumer drains this same cycle.
    always_comb begin
        ready_s = 1'b0;
        if (state_r == IDLE) begin
            ready_s = 1'b1;
        end else if (state_r == HOLD) begin
            ready_s = bus.result_ready_i;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign accept_s = bus.valid_i & ready_s;

    // Next-state and registered-output computation.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        result_s  = result_r;
        branch_s  = branch_r;
        valid_s   = valid_r;
        crash_s   = crash_r;
        req_s     = 1'b0;
        ch_s      = {CH_W{1'b0}};
        idx_s     = {IDX_W{1'b0}};
        err_s     = 1'b0;
        rst_buf_s = 1'b0;
        if (accept_s) begin
            if (is_buf_op(op_s)) begin
                state_s = BUF_WAIT;
                cnt_s   = {CNT_W{1'b0}};
                valid_s = 1'b0;
                req_s   = 1'b1;
                ch_s    = CH_W'(insa_channel(op_s));
                idx_s   = bus.fu_data_i.imm[IDX_W-1:0];
            end else begin
                state_s   = HOLD;
                result_s  = core_result_s;
                branch_s  = core_branch_s;
                valid_s   = 1'b1;
                rst_buf_s = (op_s == RSTBUF);
                case (op_s)
                    ENCRASH:  crash_s = 1'b1;
                    CLRCRASH: crash_s = 1'b0;
                    default:  crash_s = crash_r;
                endcase
            end
        end else begin
            case (state_r)
                IDLE: state_s = IDLE;
                BUF_WAIT: begin
                    // Data arriving in the timeout cycle still wins.
                    if (bus.buf_rd_valid_i) begin
                        state_s  = HOLD;
                        result_s = XLEN'(bus.buf_rd_data_i);
                        branch_s = 1'b1;
                        valid_s  = 1'b1;
                    end else if (cnt_r == CNT_W'(TIMEOUT)) begin
                        state_s  = HOLD;
                        result_s = {XLEN{1'b0}};
                        branch_s = 1'b1;
                        valid_s  = 1'b1;
                        err_s    = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1'b1);
                    end
                end
                HOLD: begin
                    if (bus.result_ready_i) begin
                        state_s = IDLE;
                        valid_s = 1'b0;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s = IDLE;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            result_r  <= {XLEN{1'b0}};
            branch_r  <= 1'b0;
            valid_r   <= 1'b0;
            req_r     <= 1'b0;
            ch_r      <= {CH_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            err_r     <= 1'b0;
            rst_buf_r <= 1'b0;
            crash_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            result_r  <= result_s;
            branch_r  <= branch_s;
            valid_r   <= valid_s;
            req_r     <= req_s;
            ch_r      <= ch_s;
            idx_r     <= idx_s;
            err_r     <= err_s;
            rst_buf_r <= rst_buf_s;
            crash_r   <= crash_s;
        end
    end

    assign bus.ready_o        = ready_s;
    assign bus.result_o       = result_r;
    assign bus.branch_res_o   = branch_r;
    assign bus.result_valid_o = valid_r;
    assign bus.buf_rd_req_o   = req_r;
    assign bus.buf_rd_ch_o    = ch_r;
    assign bus.buf_rd_idx_o   = idx_r;
    assign bus.buf_err_o      = err_r;
    assign bus.rst_buf_o      = rst_buf_r;
    assign bus.en_crash_o     = crash_r;

endmodule

// File: tb/tb_alu_insa_pipe.sv
// Self-checking bench for alu_insa_pipe: directed vector table, random ALU
// ops against a behavioural model, and hand-written buffer/handshake sequences.
module tb_alu_insa_pipe;
    import ariane_pkg::*;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned IDX_W   = 20;
    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_insa_pipe_if #(.XLEN(XLEN), .IDX_W(IDX_W), .NUM_CH(NUM_CH)) bus ();

    alu_insa_pipe #(.XLEN(XLEN), .IDX_W(IDX_W), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        fu_op_t      op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        br;
    } vec_t;

    vec_t vecs [19];

    fu_op_t alu_ops [21] = '{ADD, SUB, ADDW, SUBW, XORL, ORL, ANDL, SRA, SRL, SLL,
                             SRLW, SLLW, SRAW, LTS, LTU, GES, GEU, EQ, NE, SLTS, SLTU};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] imm);
        bus.fu_data_i.operation = op;
        bus.fu_data_i.operand_a = a;
        bus.fu_data_i.operand_b = b;
        bus.fu_data_i.imm       = imm;
        bus.valid_i             = 1'b1;
    endtask

    task automatic issue(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] imm);
        offer(op, a, b, imm);
        #1;
        check("issue_ready", bus.ready_o, 1);
        tick();
        bus.valid_i = 1'b0;
    endtask

    function automatic logic [63:0] sx32(input logic [63:0] v);
        int t;
        t = v[31:0];
        return 64'(longint'(t));
    endfunction

    // Reference: RV64I semantics from plain arithmetic on 64-bit integers.
    function automatic void ref_alu(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic br);
        longint sa, sb;
        int     w, sh, shw;
        sa  = a;
        sb  = b;
        w   = a[31:0];
        sh  = int'(b[5:0]);
        shw = int'(b[4:0]);
        r   = 64'd0;
        br  = 1'b1;
        case (op)
            ADD:  r = a + b;
            SUB:  r = a - b;
            ADDW: r = sx32(a + b);
            SUBW: r = sx32(a - b);
            XORL: r = a ^ b;
            ORL:  r = a | b;
            ANDL: r = a & b;
            SLL:  r = a << sh;
            SRL:  r = a >> sh;
            SRA:  r = sa >>> sh;
            SLLW: r = sx32(a << shw);
            SRLW: r = sx32({32'd0, a[31:0]} >> shw);
            SRAW: r = sx32(64'(w >>> shw));
            SLTS: r = (sa < sb) ? 64'd1 : 64'd0;
            SLTU: r = (a < b) ? 64'd1 : 64'd0;
            LTS:  br = (sa < sb);
            LTU:  br = (a < b);
            GES:  br = (sa >= sb);
            GEU:  br = (a >= b);
            EQ:   br = (a == b);
            NE:   br = (a != b);
            default: begin
                r  = 64'd0;
                br = 1'b1;
            end
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},   bus.ready_o, 1);
        check({tag, "_result"},  bus.result_o, 0);
        check({tag, "_branch"},  bus.branch_res_o, 0);
        check({tag, "_valid"},   bus.result_valid_o, 0);
        check({tag, "_req"},     bus.buf_rd_req_o, 0);
        check({tag, "_ch"},      bus.buf_rd_ch_o, 0);
        check({tag, "_idx"},     bus.buf_rd_idx_o, 0);
        check({tag, "_err"},     bus.buf_err_o, 0);
        check({tag, "_rstbuf"},  bus.rst_buf_o, 0);
        check({tag, "_crash"},   bus.en_crash_o, 0);
    endtask

    initial begin
        logic [63:0] ra, rb, er;
        logic        eb;

        vecs[0]  = '{ADD,  64'd5, 64'd7, 64'd12, 1'b1};
        vecs[1]  = '{ADDW, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b1};
        vecs[2]  = '{EQ,   64'd3, 64'd3, 64'd0, 1'b1};
        vecs[3]  = '{LTS,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1};
        vecs[4]  = '{LTU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0};
        vecs[5]  = '{SUB,  64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
        vecs[6]  = '{SLL,  64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b1};
        vecs[7]  = '{SLL,  64'd1, 64'd64, 64'd1, 1'b1};
        vecs[8]  = '{SRA,  64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b1};
        vecs[9]  = '{SRLW, 64'hFFFF_FFFF_8000_0000, 64'h21, 64'h0000_0000_4000_0000, 1'b1};
        vecs[10] = '{SRAW, 64'h8000_0000, 64'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[11] = '{SLTU, 64'd1, 64'd2, 64'd1, 1'b1};
        vecs[12] = '{GEU,  64'd1, 64'd2, 64'd0, 1'b0};
        vecs[13] = '{NE,   64'd4, 64'd4, 64'd0, 1'b0};
        vecs[14] = '{XORL, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b1};
        vecs[15] = '{fu_op_t'(8'hF0), 64'd1, 64'd2, 64'd0, 1'b1};
        vecs[16] = '{SUBW, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[17] = '{SLLW, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000, 1'b1};
        vecs[18] = '{GES,  64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1};

        rst_n              = 1'b0;
        bus.valid_i        = 1'b0;
        bus.fu_data_i      = '0;
        bus.result_ready_i = 1'b1;
        bus.buf_rd_valid_i = 1'b0;
        bus.buf_rd_data_i  = 32'd0;
        tick();
        tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();
        check("post_reset_ready", bus.ready_o, 1);

        // Directed vectors: result one cycle after accept.
        for (int i = 0; i < 19; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 64'd0);
            check($sformatf("vec%0d_valid", i), bus.result_valid_o, 1);
            check($sformatf("vec%0d_result", i), bus.result_o, vecs[i].res);
            check($sformatf("vec%0d_branch", i), bus.branch_res_o, vecs[i].br);
        end
        tick();
        check("drain_valid", bus.result_valid_o, 0);

        // Random ALU ops against the reference model.
        for (int i = 0; i < 300; i++) begin
            fu_op_t op;
            op = alu_ops[$urandom_range(0, 20)];
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? 64'(ra) : {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) rb = 64'($urandom_range(0, 127));
            ref_alu(op, ra, rb, er, eb);
            issue(op, ra, rb, 64'd0);
            check($sformatf("rnd%0d_%s_result", i, op.name()), bus.result_o, er);
            check($sformatf("rnd%0d_%s_branch", i, op.name()), bus.branch_res_o, eb);
        end
        tick();

        // INSAFIRST read answered three cycles after accept.
        issue(INSAFIRST, 64'd0, 64'd0, 64'h0004_2);
        check("first_req", bus.buf_rd_req_o, 1);
        check("first_ch", bus.buf_rd_ch_o, 0);
        check("first_idx", bus.buf_rd_idx_o, 20'h00042);
        check("first_wait_valid", bus.result_valid_o, 0);
        check("first_wait_ready", bus.ready_o, 0);
        tick();
        check("first_req_pulse", bus.buf_rd_req_o, 0);
        check("first_idx_zero", bus.buf_rd_idx_o, 0);
        tick();
        bus.buf_rd_valid_i = 1'b1;
        bus.buf_rd_data_i  = 32'hDEAD_BEEF;
        tick();
        bus.buf_rd_valid_i = 1'b0;
        check("first_valid", bus.result_valid_o, 1);
        check("first_result", bus.result_o, 64'h0000_0000_DEAD_BEEF);
        check("first_err", bus.buf_err_o, 0);
        tick();

        // INSALAST with no response: timeout, then a late response is ignored.
        issue(INSALAST, 64'd0, 64'd0, 64'h7);
        check("last_req", bus.buf_rd_req_o, 1);
        check("last_ch", bus.buf_rd_ch_o, 1);
        check("last_idx", bus.buf_rd_idx_o, 7);
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            tick();
            check($sformatf("last_wait%0d_err", k), bus.buf_err_o, 0);
            check($sformatf("last_wait%0d_valid", k), bus.result_valid_o, 0);
        end
        tick();
        check("timeout_err", bus.buf_err_o, 1);
        check("timeout_valid", bus.result_valid_o, 1);
        check("timeout_result", bus.result_o, 0);
        bus.buf_rd_valid_i = 1'b1;
        bus.buf_rd_data_i  = 32'h1234_5678;
        tick();
        check("timeout_err_pulse", bus.buf_err_o, 0);
        check("late_rsp_valid", bus.result_valid_o, 0);
        tick();
        bus.buf_rd_valid_i = 1'b0;
        check("late_rsp_valid2", bus.result_valid_o, 0);
        check("late_rsp_ready", bus.ready_o, 1);

        // Response in the very cycle the timeout fires: data wins.
        issue(INSAFIRST, 64'd0, 64'd0, 64'h5);
        for (int k = 1; k <= int'(TIMEOUT); k++) tick();
        bus.buf_rd_valid_i = 1'b1;
        bus.buf_rd_data_i  = 32'h8765_4321;
        tick();
        bus.buf_rd_valid_i = 1'b0;
        check("race_valid", bus.result_valid_o, 1);
        check("race_err", bus.buf_err_o, 0);
        check("race_result", bus.result_o, 64'h0000_0000_8765_4321);
        tick();

        // Crash enable and buffer clear.
        issue(ENCRASH, 64'd9, 64'd9, 64'd0);
        check("encrash_flag", bus.en_crash_o, 1);
        check("encrash_result", bus.result_o, 0);
        for (int i = 0; i < 3; i++) begin
            issue(ADD, 64'(i), 64'd1, 64'd0);
            check($sformatf("crash_hold%0d", i), bus.en_crash_o, 1);
            check($sformatf("crash_add%0d", i), bus.result_o, 64'(i + 1));
        end
        issue(CLRCRASH, 64'd0, 64'd0, 64'd0);
        check("clrcrash_flag", bus.en_crash_o, 0);
        check("clrcrash_result", bus.result_o, 0);
        issue(RSTBUF, 64'd3, 64'd4, 64'd0);
        check("rstbuf_pulse", bus.rst_buf_o, 1);
        check("rstbuf_result", bus.result_o, 0);
        check("rstbuf_valid", bus.result_valid_o, 1);
        tick();
        check("rstbuf_single", bus.rst_buf_o, 0);

        // Backpressure, then drain and accept in the same cycle.
        bus.result_ready_i = 1'b0;
        issue(ADD, 64'd10, 64'd20, 64'd0);
        offer(SUB, 64'd100, 64'd1, 64'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp%0d_ready", k), bus.ready_o, 0);
            tick();
            check($sformatf("bp%0d_valid", k), bus.result_valid_o, 1);
            check($sformatf("bp%0d_result", k), bus.result_o, 30);
        end
        bus.result_ready_i = 1'b1;
        #1;
        check("bp_drain_ready", bus.ready_o, 1);
        tick();
        bus.valid_i = 1'b0;
        check("bp_next_valid", bus.result_valid_o, 1);
        check("bp_next_result", bus.result_o, 99);
        tick();

        // Reset while waiting on the buffer.
        issue(ENCRASH, 64'd0, 64'd0, 64'd0);
        issue(INSAFIRST, 64'd0, 64'd0, 64'h9);
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        check("after_reset_valid", bus.result_valid_o, 0);
        check("after_reset_crash", bus.en_crash_o, 0);
        check("after_reset_ready", bus.ready_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
